mux4_sel_ctrl: RTL and testbench

Round-robin select controller that sits directly upstream of the `mux4` 4→1 multiplexer. It arbitrates four channel requests and drives the mux `sel[1:0]` with a valid/ready handshake toward the consumer. Each granted channel keeps the mux for a burst of up to `BURST` accepted beats, then the grant rotates. It turns the combinational mux into a fair, time-shared 4-channel path.

---
 rtl/mux4_sel_ctrl.sv | 122 ++++++++++++
 tb/tb_mux4_sel_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mux4_sel_ctrl.sv
// rtl/mux4_sel_ctrl.sv - burst round-robin select controller feeding a mux4 (option: MUX4_SEL_FIXED_PRIO_EN)
module mux4_sel_ctrl #(
  parameter int BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic       valid,
  output logic [3:0] grant,
  output logic       last
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_n;
  logic [1:0]    sel_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          valid_n, last_n;
  logic [3:0]    grant_n;
  logic          expiry, burst_end;

`ifdef MUX4_SEL_FIXED_PRIO_EN
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    logic [1:0] w;
    w = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r[k]) w = 2'(k);
    end
    return w;
  endfunction
`else
  logic [1:0] ptr, ptr_n;
  logic [3:0] cand;

  // Search ptr+1, ptr+2, ptr+3, ptr; iterating downward lets the nearest hit win.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    w = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction
`endif

  always_comb begin
    state_n   = state;
    sel_n     = sel;
    cnt_n     = cnt;
    expiry    = (state == BUSY) && out_ready && (cnt == CNT_LAST);
    burst_end = (state == BUSY) && (expiry || !req[sel]);
`ifndef MUX4_SEL_FIXED_PRIO_EN
    ptr_n     = ptr;
    cand      = req & ~(4'b0001 << sel);
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = BUSY;
          cnt_n   = '0;
`ifdef MUX4_SEL_FIXED_PRIO_EN
          sel_n   = pick_fixed(req);
`else
          sel_n   = pick_rr(req, ptr);
`endif
        end
      end
      BUSY: begin
        if (burst_end) begin
          cnt_n = '0;
`ifdef MUX4_SEL_FIXED_PRIO_EN
          if (|req) sel_n = pick_fixed(req);
          else      state_n = IDLE;
`else
          ptr_n = sel;
          // With no other requester, a still-requesting channel can only be here on expiry: keep it.
          if (|cand)         sel_n = pick_rr(cand, sel);
          else if (!req[sel]) state_n = IDLE;
`endif
        end else if (out_ready) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    valid_n = (state_n == BUSY);
    grant_n = valid_n ? (4'b0001 << sel_n) : 4'b0000;
    last_n  = valid_n && (cnt_n == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 2'd0;
      cnt   <= '0;
      valid <= 1'b0;
      grant <= 4'b0000;
      last  <= 1'b0;
`ifndef MUX4_SEL_FIXED_PRIO_EN
      ptr   <= 2'd3;
`endif
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      valid <= valid_n;
      grant <= grant_n;
      last  <= last_n;
`ifndef MUX4_SEL_FIXED_PRIO_EN
      ptr   <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_mux4_sel_ctrl.sv
// tb/tb_mux4_sel_ctrl.sv - directed vector bench for mux4_sel_ctrl
module tb_mux4_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic       valid;
  logic [3:0] grant;
  logic       last;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       v;
    logic [1:0] sel;
    logic       last;
  } vec_t;

  vec_t vecs[$];

  mux4_sel_ctrl #(.BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .valid     (valid),
    .grant     (grant),
    .last      (last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic rd,
                     input logic v, input logic [1:0] s, input logic l);
    vec_t e;
    e.rst = r; e.req = q; e.rdy = rd; e.v = v; e.sel = s; e.last = l;
    vecs.push_back(e);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [1:0] first_sel;
    int         beats;
    int         n;
    bit         changed;

    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;

    // Reset then first arbitration from ptr=3
    add(1, 4'b1111, 1, 0, 2'd0, 0);
    add(1, 4'b1111, 1, 0, 2'd0, 0);
`ifdef MUX4_SEL_FIXED_PRIO_EN
    add(0, 4'b1111, 1, 1, 2'd0, 0);
    add(1, 4'b1110, 1, 0, 2'd0, 0);
    for (int j = 0; j < 17; j++)
      add(0, (j < 6) ? 4'b1110 : 4'b1111, 1, 1, (j < 8) ? 2'd1 : 2'd0, (j % 4) == 3);
`else
    for (int i = 0; i < 17; i++)
      add(0, 4'b1111, 1, 1, 2'((i / 4) % 4), (i % 4) == 3);
    // Sole requester re-wins with no bubble
    add(1, 4'b0001, 1, 0, 2'd0, 0);
    for (int i = 0; i < 9; i++)
      add(0, 4'b0001, 1, 1, 2'd0, (i % 4) == 3);
    // Backpressure after beat 2: last follows accepted beats, not cycles
    add(0, 4'b0001, 1, 1, 2'd0, 0);
    add(0, 4'b0001, 1, 1, 2'd0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b0001, 0, 1, 2'd0, 0);
    add(0, 4'b0001, 1, 1, 2'd0, 1);
    add(0, 4'b0001, 1, 1, 2'd0, 0);
    // Request drop on channel 2
    add(1, 4'b0100, 1, 0, 2'd0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b0100, 1, 1, 2'd2, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b1001, 1, 1, 2'd3, i == 3);
    add(0, 4'b1001, 1, 1, 2'd0, 0);
    // Drop to idle, re-request, then reset mid-burst
    add(0, 4'b0000, 1, 0, 2'd0, 0);
    add(0, 4'b0010, 1, 1, 2'd1, 0);
    add(0, 4'b0010, 1, 1, 2'd1, 0);
    add(1, 4'b0010, 1, 0, 2'd0, 0);
    add(0, 4'b0010, 1, 1, 2'd1, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; out_ready = vecs[i].rdy;
      @(posedge clk); #1;
      exp_g = vecs[i].v ? (4'b0001 << vecs[i].sel) : 4'b0000;
      check($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].v));
      check($sformatf("row%0d grant", i), 32'(grant), 32'(exp_g));
      check($sformatf("row%0d last", i), 32'(last), 32'(vecs[i].last));
      if (vecs[i].v || vecs[i].rst)
        check($sformatf("row%0d sel", i), 32'(sel), 32'(vecs[i].sel));
    end

`ifndef MUX4_SEL_FIXED_PRIO_EN
    // Irregular backpressure: exactly 4 accepted beats per burst, last on the 4th
    rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (!valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("hs valid", 32'(valid), 32'd1);
    first_sel = sel;
    beats = 0;
    changed = 1'b0;
    for (int c = 0; c < 60 && !changed; c++) begin
      out_ready = ((c % 3) != 1);
      #1;
      if (valid && out_ready) begin
        check($sformatf("hs last beat%0d", beats), 32'(last), 32'(beats == 3));
        beats++;
      end
      @(posedge clk); #1;
      if (sel != first_sel) changed = 1'b1;
    end
    check("hs rotated", 32'(changed), 32'd1);
    check("hs first sel", 32'(first_sel), 32'd0);
    check("hs beats", 32'(beats), 32'd4);
    check("hs next sel", 32'(sel), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
